regbank_access_arbiter: RTL and testbench
=========================================

// Module: regbank_access_arbiter
// PURPOSE
//  Shares the single-port 128x16 register bank among NREQ requesters: execute stage, operand fetch, debug loader.
//  Serialises READ, WRITE and ISZ read-modify-write (increment, zero test for the skip flag) transactions.
//  Round-robin arbitration. Sits between the pipeline stages and the bank macro.
// PARAMETERS
//  NREQ  3   number of requesters (2..8)
//  AW    7   bank address width (128 words)
//  DW    16  bank data width
// PORTS
//  clk1       in   1        single clock; all logic on posedge clk1
//  rst        in   1        synchronous, active-high reset
//  req_valid  in   NREQ     per-requester request
//  req_op     in   2*NREQ   per-requester op, slice i = [2i+1:2i]; 00 READ, 01 WRITE, 10 ISZ, 11 illegal
//  req_addr   in   AW*NREQ  per-requester address, slice i = [AW*i+AW-1:AW*i]
//  req_wdata  in   DW*NREQ  per-requester write data (WRITE only)
//  gnt        out  NREQ     one-hot accept strobe; transfer occurs when req_valid[i]&gnt[i]
//  rsp_valid  out  NREQ     one-hot, 1-cycle completion pulse to the owning requester
//  rsp_rdata  out  DW       READ: bank word; ISZ: incremented word; WRITE: 0
//  rsp_zero   out  1        ISZ only: incremented word == 0 (skip request)
//  rsp_err    out  1        illegal op completed with no bank access
//  busy       out  1        transaction in flight (state != IDLE)
//  bank_addr  out  AW       bank address
//  bank_we    out  1        bank write enable
//  bank_wdata out  DW       bank write data
//  bank_rdata in   DW       bank read data; synchronous, valid 1 cycle after bank_addr
// BEHAVIOUR
//  Reset: state=IDLE; gnt, rsp_valid, rsp_zero, rsp_err, busy, bank_we = 0; rsp_rdata, bank_addr, bank_wdata = 0.
//  Reset: RR pointer = NREQ-1, so requester 0 wins first. Reset mid-transaction aborts it: no bank_we, no rsp_valid.
//  gnt is combinational and asserted only in IDLE: at most one bit, winner = first valid after pointer, with wrap.
//  On accept, latch op/addr/wdata/owner; pointer <- winner index.
//  FSM: IDLE, RD, CAP, WR, RSP. Accept at cycle c:
//   WRITE: WR c+1 (bank_we=1, bank_wdata=latched wdata); RSP c+2.
//   READ:  RD c+1 (bank_addr); CAP c+2 (latch bank_rdata); RSP c+3.
//   ISZ:   RD c+1; CAP c+2; WR c+3 (write latched+1, modulo 2^DW); RSP c+4.
//   ILLEGAL: RSP c+1 with rsp_err=1; no bank access.
//  RSP: rsp_valid[owner]=1 for exactly one cycle, then IDLE. No accept during RSP; next gnt at earliest cycle after RSP.
//  Response outputs are registered and held until the next RSP; only rsp_valid qualifies them.
//  ISZ wrap: 16'hFFFF -> writes 0, rsp_rdata=0, rsp_zero=1.
//  bank_addr holds the latched address from RD through WR; 0 in IDLE. bank_we=1 only in WR.
//  A requester may drop req_valid before gnt; no request is remembered.
//  Simultaneous requests: exactly one gnt; the losers keep req_valid and are served in RR order.
// CONFIGURATION
//  REGBANK_ARB_PRIO_EN defined: requester 0 (execute stage) always wins when valid.
//   Requesters 1..NREQ-1 rotate round-robin among themselves; the pointer ignores grants to 0.
//  Not defined: pure round-robin over all NREQ requesters.
// STRUCTURE
//  Package regbank_arb_pkg: op encodings OP_READ/OP_WRITE/OP_ISZ/OP_ILL, FSM state localparams.
//  Sub-module rr_pick: combinational round-robin picker (req vector, pointer -> one-hot + index), NREQ-parameterised.
// TESTING
//  1. Reset, then req0 WRITE addr 5 data 16'h1234: gnt[0] same cycle, bank_we at c+1, rsp_valid[0] at c+2.
//  2. req1 READ addr 5 after test 1: rsp_valid[1] at c+3 with rsp_rdata=16'h1234, rsp_err=0.
//  3. bank[9]=16'hFFFF, req2 ISZ addr 9: bank[9]=0 written at c+3; rsp at c+4 with rsp_rdata=0, rsp_zero=1.
//  4. All three requesters held valid for 9 grants: order 0,1,2,0,1,2,0,1,2 (macro off).
//     Macro on: 0 wins every arbitration while valid.
//  5. req0 op 11: rsp_valid[0] at c+1, rsp_err=1, bank_we never asserted.
//  6. rst pulsed during CAP of an ISZ: no bank_we, no rsp_valid, busy=0; next grant goes to requester 0.

Source files
------------

// File: rtl/regbank_arb_pkg.sv
// rtl/regbank_arb_pkg.sv - op encodings and FSM states for the register bank access arbiter
package regbank_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ISZ   = 2'b10,
        OP_ILL   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RSP
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request after ptr, with wrap
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            found
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        // Scan ptr+1 .. ptr+NREQ so the last winner has the lowest priority
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_access_arbiter.sv
// rtl/regbank_access_arbiter.sv - serialises READ/WRITE/ISZ bank transactions; REGBANK_ARB_PRIO_EN gives requester 0 fixed priority
module regbank_access_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = 7,
    parameter int DW   = 16
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [2*NREQ-1:0]  req_op,
    input  logic [AW*NREQ-1:0] req_addr,
    input  logic [DW*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic               busy,
    output logic [AW-1:0]      bank_addr,
    output logic               bank_we,
    output logic [DW-1:0]      bank_wdata,
    input  logic [DW-1:0]      bank_rdata
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    op_t             op_q;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [DW-1:0]   data_q;
    logic [NREQ-1:0] owner_onehot;

    logic [NREQ-1:0] pick_req, pick_onehot, win_onehot;
    logic [IW-1:0]   pick_idx, win_idx;
    logic            pick_found, win_any, ptr_upd;

    op_t             sel_op;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req    (pick_req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

`ifdef REGBANK_ARB_PRIO_EN
    // Execute stage pre-empts the rotation; grants to it leave the pointer alone
    assign pick_req   = {req_valid[NREQ-1:1], 1'b0};
    assign win_onehot = req_valid[0] ? NREQ'(1) : pick_onehot;
    assign win_idx    = req_valid[0] ? '0 : pick_idx;
    assign win_any    = req_valid[0] | pick_found;
    assign ptr_upd    = ~req_valid[0];
`else
    assign pick_req   = req_valid;
    assign win_onehot = pick_onehot;
    assign win_idx    = pick_idx;
    assign win_any    = pick_found;
    assign ptr_upd    = 1'b1;
`endif

    always_comb begin
        sel_op    = OP_READ;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                sel_op    = op_t'(req_op[2*i +: 2]);
                sel_addr  = req_addr[AW*i +: AW];
                sel_wdata = req_wdata[DW*i +: DW];
            end
        end
    end

    assign gnt          = (state == ST_IDLE && !rst) ? win_onehot : '0;
    assign busy         = (state != ST_IDLE);
    assign owner_onehot = NREQ'(1) << owner;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_READ;
            ptr        <= IW'(NREQ - 1);
            owner      <= '0;
            data_q     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            bank_addr  <= '0;
            bank_we    <= 1'b0;
            bank_wdata <= '0;
        end else begin
            rsp_valid <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        owner <= win_idx;
                        op_q  <= sel_op;
                        if (ptr_upd) ptr <= win_idx;
                        unique case (sel_op)
                            OP_WRITE: begin
                                state      <= ST_WR;
                                bank_addr  <= sel_addr;
                                bank_we    <= 1'b1;
                                bank_wdata <= sel_wdata;
                            end
                            OP_READ, OP_ISZ: begin
                                state     <= ST_RD;
                                bank_addr <= sel_addr;
                            end
                            default: begin
                                state     <= ST_RSP;
                                rsp_valid <= win_onehot;
                                rsp_rdata <= '0;
                                rsp_zero  <= 1'b0;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RD: state <= ST_CAP;
                ST_CAP: begin
                    if (op_q == OP_ISZ) begin
                        state      <= ST_WR;
                        data_q     <= bank_rdata + DW'(1);
                        bank_we    <= 1'b1;
                        bank_wdata <= bank_rdata + DW'(1);
                    end else begin
                        state     <= ST_RSP;
                        bank_addr <= '0;
                        rsp_valid <= owner_onehot;
                        rsp_rdata <= bank_rdata;
                        rsp_zero  <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                ST_WR: begin
                    state     <= ST_RSP;
                    bank_we   <= 1'b0;
                    bank_addr <= '0;
                    rsp_valid <= owner_onehot;
                    rsp_rdata <= (op_q == OP_ISZ) ? data_q : '0;
                    rsp_zero  <= (op_q == OP_ISZ) && (data_q == '0);
                    rsp_err   <= 1'b0;
                end
                ST_RSP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// tb/tb_regbank_access_arbiter.sv - randomized self-checking bench for regbank_access_arbiter
module tb_regbank_access_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 7;
    localparam int DW   = 16;

    logic               clk1 = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [2*NREQ-1:0]  req_op;
    logic [AW*NREQ-1:0] req_addr;
    logic [DW*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    gnt, rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_zero, rsp_err, busy;
    logic [AW-1:0]      bank_addr;
    logic               bank_we;
    logic [DW-1:0]      bank_wdata, bank_rdata;

    logic [DW-1:0] mem     [128];
    logic [DW-1:0] ref_mem [128];
    int checks   = 0;
    int failures = 0;
    int we_count = 0;
    int ref_ptr;

    always #5 clk1 = ~clk1;

    regbank_access_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .bank_addr  (bank_addr),
        .bank_we    (bank_we),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata)
    );

    // Bank macro: synchronous read, one cycle latency
    always @(posedge clk1) begin
        if (bank_we) begin
            mem[bank_addr] <= bank_wdata;
            we_count       <= we_count + 1;
        end
        bank_rdata <= mem[bank_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    function automatic int model_winner(input logic [NREQ-1:0] mask, input int ptr);
`ifdef REGBANK_ARB_PRIO_EN
        if (mask[0]) return 0;
        mask[0] = 1'b0;
`endif
        for (int k = 1; k <= NREQ; k++)
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_op[2*i +: 2]     = op;
        req_addr[AW*i +: AW] = a;
        req_wdata[DW*i +: DW] = d;
        req_valid[i]         = 1'b1;
    endtask

    // Arbitrate the currently driven requests and follow the winner to completion
    task automatic run_grant();
        int w, lat, we_k;
        logic [1:0] op;
        logic [AW-1:0] a;
        logic [DW-1:0] d, exp_rd, wr_val;
        logic exp_zero, exp_err;
        #1;
        w = model_winner(req_valid, ref_ptr);
        if (w < 0) begin
            check_eq("gnt_none", 32'(gnt), 32'd0);
            return;
        end
        check_eq("gnt", 32'(gnt), 32'(1 << w));
        op = req_op[2*w +: 2];
        a  = req_addr[AW*w +: AW];
        d  = req_wdata[DW*w +: DW];
        exp_rd = '0; exp_zero = 1'b0; exp_err = 1'b0; wr_val = '0; we_k = 0;
        case (op)
            2'b00: begin lat = 3; exp_rd = ref_mem[a]; end
            2'b01: begin lat = 2; we_k = 1; wr_val = d; end
            2'b10: begin lat = 4; we_k = 3; wr_val = ref_mem[a] + 16'd1; exp_rd = wr_val; exp_zero = (wr_val == 16'd0); end
            default: begin lat = 1; exp_err = 1'b1; end
        endcase
`ifdef REGBANK_ARB_PRIO_EN
        if (w != 0) ref_ptr = w;
`else
        ref_ptr = w;
`endif
        @(posedge clk1);
        #1;
        req_valid[w] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) step();
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("gnt_busy", 32'(gnt), 32'd0);
            check_eq("rsp_valid", 32'(rsp_valid), (k == lat) ? 32'(1 << w) : 32'd0);
            check_eq("bank_we", 32'(bank_we), 32'(k == we_k));
            if (k == we_k) begin
                check_eq("bank_addr", 32'(bank_addr), 32'(a));
                check_eq("bank_wdata", 32'(bank_wdata), 32'(wr_val));
            end
            if (k == lat) begin
                check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
                check_eq("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
                check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
        if (we_k != 0) ref_mem[a] = wr_val;
        step();
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("rsp_valid_done", 32'(rsp_valid), 32'd0);
        check_eq("bank_addr_idle", 32'(bank_addr), 32'd0);
        check_eq("rsp_hold", 32'(rsp_rdata), 32'(exp_rd));
    endtask

    initial begin
        int we0;
        logic [DW-1:0] v;
        rst = 1'b1;
        req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 128; i++) begin
            v = DW'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        ref_ptr = NREQ - 1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_bank_we", 32'(bank_we), 32'd0);
        check_eq("rst_bank_addr", 32'(bank_addr), 32'd0);
        check_eq("rst_bank_wdata", 32'(bank_wdata), 32'd0);
        check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);

        // Directed: write, read back, ISZ wrap, illegal op
        set_req(0, 2'b01, 7'd5, 16'h1234);
        run_grant();
        set_req(1, 2'b00, 7'd5, 16'h0);
        run_grant();
        mem[9] = 16'hFFFF;
        ref_mem[9] = 16'hFFFF;
        set_req(2, 2'b10, 7'd9, 16'h0);
        run_grant();
        check_eq("isz_wrap_mem", 32'(mem[9]), 32'd0);
        we0 = we_count;
        set_req(0, 2'b11, 7'd3, 16'h0);
        run_grant();
        check_eq("ill_no_we", we_count, we0);

        // All requesters held valid for nine grants
        for (int g = 0; g < 9; g++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i]) set_req(i, 2'b00, AW'(i + 20), 16'h0);
            run_grant();
        end
        req_valid = '0;

        // Randomized mix of masks, ops and a small address window
        for (int n = 0; n < 60; n++) begin
            req_valid = '0;
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 1) == 1)
                    set_req(i, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), DW'($urandom));
            if ($urandom_range(0, 7) == 0)
                set_req(int'($urandom_range(0, NREQ - 1)), 2'b10, 7'd9, 16'h0);
            run_grant();
        end
        req_valid = '0;

        // Reset during CAP of an ISZ aborts it cleanly
        set_req(2, 2'b10, 7'd11, 16'h0);
        #1;
        check_eq("abort_gnt", 32'(gnt), 32'(model_winner(req_valid, ref_ptr) >= 0 ? (1 << model_winner(req_valid, ref_ptr)) : 0));
        @(posedge clk1);
        #1;
        req_valid = '0;
        step();
        we0 = we_count;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_bank_we", 32'(bank_we), 32'd0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("abort_quiet", {30'd0, bank_we, |rsp_valid}, 32'd0);
        end
        check_eq("abort_mem", 32'(mem[11]), 32'(ref_mem[11]));
        check_eq("abort_we_count", we_count, we0);
        ref_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, AW'(11), 16'h0);
        run_grant();
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
